wb_regfile: RTL and testbench

Write-back end of the MEM-stage write request (address, enable, data). Latches the MEM-stage request in a MEM/WB pipeline register, then commits it to the general-purpose register file on the following edge. Serves two combinational read ports to the decode stage, with write-through bypass from the pending write-back.

---
 rtl/wb_regfile_pkg.sv | 28 ++
 rtl/wb_regfile_if.sv | 46 ++++
 rtl/wb_regfile_array.sv | 43 ++++
 rtl/wb_regfile.sv | 54 +++++
 tb/tb_wb_regfile.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, constants and the write-request struct used
// by the MEM/WB latch and the register array.
//   DW        register/data width
//   AW        register address width
//   NREG      number of registers (2**AW)
//   NUM_RD    number of combinational read ports
//   ZERO_WORD all-zero data word
//   REG_ZERO  address of the hardwired-zero register
//   wr_req_t  {addr, en, data} write request
package wb_regfile_pkg;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NREG   = 2**AW;
  localparam int NUM_RD = 2;

  localparam logic [DW-1:0] ZERO_WORD = 32'h0;
  localparam logic [AW-1:0] REG_ZERO  = 5'd0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          en;
    logic [DW-1:0] data;
  } wr_req_t;

  localparam wr_req_t WR_BUBBLE = '{addr: REG_ZERO, en: 1'b0, data: ZERO_WORD};

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bus bundle between the MEM/decode stages and the write-back
// register file.
//   wd_addr/wd_en/wd_data  MEM-stage write request
//   stall/flush            bubble insertion into MEM/WB
//   re1/raddr1/rdata1      read port 1
//   re2/raddr2/rdata2      read port 2
//   wb_addr/wb_en/wb_data  latched write-back request (debug/forwarding)
// slave  : the register file side
// master : the pipeline (driver) side
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int AW_P = AW
);

  logic [AW_P-1:0] wd_addr;
  logic            wd_en;
  logic [DW_P-1:0] wd_data;
  logic            stall;
  logic            flush;
  logic            re1;
  logic [AW_P-1:0] raddr1;
  logic [DW_P-1:0] rdata1;
  logic            re2;
  logic [AW_P-1:0] raddr2;
  logic [DW_P-1:0] rdata2;
  logic [AW_P-1:0] wb_addr;
  logic            wb_en;
  logic [DW_P-1:0] wb_data;

  modport slave (
    input  wd_addr, wd_en, wd_data, stall, flush,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2,
    output wb_addr, wb_en, wb_data
  );

  modport master (
    output wd_addr, wd_en, wd_data, stall, flush,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2,
    input  wb_addr, wb_en, wb_data
  );

endinterface

// File: rtl/wb_regfile_array.sv
// regfile_array: NREG x DW general-purpose register storage.
//   clk    rising-edge clock
//   reset  asynchronous active-low clear of every register
//   wr     committed write request (from the MEM/WB latch)
//   re     per-port read enable
//   raddr  per-port read address
//   rdata  per-port combinational read data, with bypass from wr
// Register 0 is never written and always reads as zero.
module regfile_array
  import wb_regfile_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  wr_req_t                      wr,
  input  logic [NUM_RD-1:0]            re,
  input  logic [NUM_RD-1:0][AW-1:0]    raddr,
  output logic [NUM_RD-1:0][DW-1:0]    rdata
);

  logic [NREG-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (wr.en && (wr.addr != REG_ZERO)) begin
      mem[wr.addr] <= wr.data;
    end
  end

  // The pending write-back is newer than the array, so it wins on a hit.
  // The zero-address check sits ahead of the bypass so r0 stays zero even
  // when a write to r0 is in flight.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit;
    assign hit = wr.en && (raddr[p] == wr.addr);
    assign rdata[p] = !reset                  ? ZERO_WORD :
                      !re[p]                  ? ZERO_WORD :
                      (raddr[p] == REG_ZERO)  ? ZERO_WORD :
                      hit                     ? wr.data   :
                                                mem[raddr[p]];
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back end of the pipeline. Latches the MEM-stage write
// request into the MEM/WB register and commits it to the register array on
// the following edge; decode reads through two combinational ports that
// bypass the pending write-back.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = in reset)
//   bus    wb_regfile_if.slave (MEM request, stall/flush, read ports,
//          latched write-back outputs)
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  wb_regfile_if.slave   bus
);

  wr_req_t                   wb_q;
  logic [NUM_RD-1:0]         re;
  logic [NUM_RD-1:0][AW-1:0] raddr;
  logic [NUM_RD-1:0][DW-1:0] rdata;

  // MEM/WB latch. Flush and stall both turn the slot into a full bubble,
  // flush first; a bubble clears address and data too so the debug outputs
  // read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= WR_BUBBLE;
    end else if (bus.flush || bus.stall) begin
      wb_q <= WR_BUBBLE;
    end else begin
      wb_q <= '{addr: bus.wd_addr, en: bus.wd_en, data: bus.wd_data};
    end
  end

  assign bus.wb_addr = wb_q.addr;
  assign bus.wb_en   = wb_q.en;
  assign bus.wb_data = wb_q.data;

  assign re    = {bus.re2, bus.re1};
  assign raddr = {bus.raddr2, bus.raddr1};

  regfile_array u_array (
    .clk   (clk),
    .reset (reset),
    .wr    (wb_q),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.rdata1 = rdata[0];
  assign bus.rdata2 = rdata[1];

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic against a
// behavioural model of the write-back register file.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: architectural register contents plus the one write in flight.
  logic [DW-1:0] regs [NREG];
  logic          p_en;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    p_en = 1'b0; p_addr = '0; p_data = '0;
  endfunction

  // Newest value of register a as seen by decode.
  function automatic logic [DW-1:0] model_rd(input logic en, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst_n || !en || a == 0) return '0;
    v = regs[a];
    if (p_en && p_addr == a) v = p_data;
    return v;
  endfunction

  task automatic chk_rd(input string tag);
    chk({tag, ".rdata1"}, bus.rdata1, model_rd(bus.re1, bus.raddr1));
    chk({tag, ".rdata2"}, bus.rdata2, model_rd(bus.re2, bus.raddr2));
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".wb_en"},   {31'd0, bus.wb_en}, {31'd0, p_en});
    chk({tag, ".wb_addr"}, {27'd0, bus.wb_addr}, {27'd0, p_addr});
    chk({tag, ".wb_data"}, bus.wb_data, p_data);
    chk_rd(tag);
  endtask

  // One clock edge: model commits the old pending write, then takes the new
  // request unless bubbled. Outputs are checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (p_en && p_addr != 0) regs[p_addr] = p_data;
      if (bus.flush || bus.stall) begin
        p_en = 1'b0; p_addr = '0; p_data = '0;
      end else begin
        p_en = bus.wd_en; p_addr = bus.wd_addr; p_data = bus.wd_data;
      end
    end
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic st, input logic fl);
    bus.wd_en = en; bus.wd_addr = a; bus.wd_data = d; bus.stall = st; bus.flush = fl;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.re1 = 1'b1; bus.raddr1 = a1; bus.re2 = 1'b1; bus.raddr2 = a2;
  endtask

  initial begin
    model_clear();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rd('0, '0);
    #1 rst_n = 1'b0;

    // Reset held: requests must not latch, reads stay zero.
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rd(5'd3, 5'd3);
    #1 chk_all("reset_hold");
    repeat (3) step("reset_hold");
    chk("reset.rdata1_const", bus.rdata1, 32'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 chk_all("reset_rel");

    // Basic write: bypass after edge 1, array after edge 2.
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
    rd(5'd5, 5'd5);
    step("basic_e1");
    chk("basic.bypass", bus.rdata1, 32'h1234_5678);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("basic_e2");
    chk("basic.array", bus.rdata1, 32'h1234_5678);

    // r0 protection.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd(5'd0, 5'd0);
    step("r0_e1");
    chk("r0.bypass", bus.rdata1, 32'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("r0_e2");
    chk("r0.array", bus.rdata1, 32'h0);

    // Stall, flush, and both together.
    rd(5'd7, 5'd7);
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b0);
    step("stall");
    chk("stall.wb_en", {31'd0, bus.wb_en}, 32'd0);
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 1'b1);
    step("flush");
    chk("flush.wb_en", {31'd0, bus.wb_en}, 32'd0);
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b1);
    step("stall_flush");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("sf_idle");
    step("sf_idle2");
    chk("stall.reg7", bus.rdata1, 32'h0);

    // Back-to-back to the same register.
    rd(5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h1, 1'b0, 1'b0);
    step("b2b_e1");
    drive(1'b1, 5'd9, 32'h2, 1'b0, 1'b0);
    step("b2b_e2");
    chk("b2b.rdata1", bus.rdata1, 32'h2);
    chk("b2b.rdata2", bus.rdata2, 32'h2);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("b2b_e3");
    chk("b2b.array", bus.rdata1, 32'h2);

    // Mid-operation reset kills the pending write.
    rd(5'd4, 5'd5);
    drive(1'b1, 5'd4, 32'h0000_CAFE, 1'b0, 1'b0);
    step("midrst_latch");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_clear();
    #1 chk_all("midrst_low");
    #2 rst_n = 1'b1;
    step("midrst_e1");
    step("midrst_e2");
    chk("midrst.reg4", bus.rdata1, 32'h0);
    chk("midrst.wb_en", {31'd0, bus.wb_en}, 32'd0);
    chk("midrst.reg5", bus.rdata2, 32'h0);

    // Randomized traffic; small address range half the time to force hits.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] wa;
      wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      drive(1'($urandom), wa, $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      bus.re1 = ($urandom_range(0, 5) != 0);
      bus.re2 = ($urandom_range(0, 5) != 0);
      bus.raddr1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      bus.raddr2 = ($urandom_range(0, 1) == 1) ? bus.raddr1 : AW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_clear();
        #1 chk_all("rnd_rst");
        rst_n = 1'b1;
      end
      #1 chk_rd("rnd_pre");
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
